// File: rtl/pl_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pl_hazard_ctrl_if
// Description : Pipeline-to-hazard-controller bundle. Carries the stage
//               hazard inputs, the per-stage load enables, the bubble
//               flushes, the halted flag and the stall-cycle count.
//               master = pipeline side, slave = hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pl_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             ihit;
   logic             dmem_req;
   logic             dhit;
   logic             idex_MemRead;
   logic [4:0]       idex_rt;
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic             ifid_uses_rt;
   logic             branch_taken;
   logic             halt_in;
   logic             pc_WEN;
   logic             ifid_WEN;
   logic             idex_WEN;
   logic             exmem_WEN;
   logic             memwb_WEN;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic             halted;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output ihit, dmem_req, dhit, idex_MemRead, idex_rt, ifid_rs, ifid_rt,
             ifid_uses_rt, branch_taken, halt_in,
      input  pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN,
             ifid_flush, idex_flush, exmem_flush, halted, stall_cycles
   );

   modport slave (
      input  ihit, dmem_req, dhit, idex_MemRead, idex_rt, ifid_rs, ifid_rt,
             ifid_uses_rt, branch_taken, halt_in,
      output pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN,
             ifid_flush, idex_flush, exmem_flush, halted, stall_cycles
   );
endinterface
`default_nettype wire

// File: rtl/pl_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pl_hazard_ctrl
// Description : Five-stage pipeline hazard controller. Produces the stage
//               register load enables and bubble flushes from the memory
//               wait, branch redirect, load-use and fetch wait conditions,
//               and latches a sticky HALTED state.
//               Optional macro HAZARD_PERF_CNT_EN adds a saturating count
//               of cycles in which the PC was held.
// Revision    : 1.0 - initial release
// ============================================================================
module pl_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  wire              CLK,
   input  wire              RST,
   pl_hazard_ctrl_if.slave  hz
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALTED   = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   halted_q, halted_d;

   // Enables packed as {pc, ifid, idex, exmem, memwb}; flushes as {ifid, idex, exmem}
   logic [4:0] wen;
   logic [2:0] flush;
   logic       load_use;
   logic       mem_wait;

   // Hazard detection; a load to r0 never creates a dependency
   always_comb begin
      load_use = hz.idex_MemRead && (hz.idex_rt != 5'd0) &&
                 ((hz.idex_rt == hz.ifid_rs) ||
                  (hz.ifid_uses_rt && (hz.idex_rt == hz.ifid_rt)));
      mem_wait = hz.dmem_req && !hz.dhit;
   end

   // Enables, flushes and next state by priority: halted > mem wait > branch > load-use > fetch wait
   always_comb begin
      wen     = 5'b11111;
      flush   = 3'b000;
      state_d = state_q;
      if (RST) begin
         wen     = 5'b00000;
         flush   = 3'b111;
         state_d = RUN;
      end else begin
         case (state_q)
            HALTED: begin
               wen = 5'b00000;
            end
            MEM_WAIT: begin
               if (hz.dhit) begin
                  state_d = RUN;
               end else begin
                  wen = 5'b00000;
               end
            end
            default: begin
               if (mem_wait) begin
                  wen     = 5'b00000;
                  state_d = MEM_WAIT;
               end else begin
                  if (hz.branch_taken) begin
                     flush = 3'b111;
                  end else if (load_use || !hz.ihit) begin
                     // Hold PC and IF/ID, inject a bubble into ID/EX
                     wen   = 5'b00111;
                     flush = 3'b010;
                  end
                  // HALT retires its cycle normally, then the pipe freezes
                  if (hz.halt_in) begin
                     state_d = HALTED;
                  end
               end
            end
         endcase
      end
      halted_d = (state_d == HALTED);
   end

   // State and registered halted flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= RUN;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   assign hz.pc_WEN      = wen[4];
   assign hz.ifid_WEN    = wen[3];
   assign hz.idex_WEN    = wen[2];
   assign hz.exmem_WEN   = wen[1];
   assign hz.memwb_WEN   = wen[0];
   assign hz.ifid_flush  = flush[2];
   assign hz.idex_flush  = flush[1];
   assign hz.exmem_flush = flush[0];
   assign hz.halted      = halted_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   // Count PC-hold cycles while not halted, sticking at all-ones
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if ((state_q != HALTED) && !wen[4] && (stall_cycles_q != {CNT_W{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Counter register
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cycles_q <= {CNT_W{1'b0}};
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign hz.stall_cycles = stall_cycles_q;
`else
   assign hz.stall_cycles = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: doc/pl_hazard_ctrl.md
PL_HAZARD_CTRL -- requirements
Module: pl_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-002 SHALL have port CLK  in  1  rising-edge clock; the block uses one clock.
REQ-003 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port ihit  in  1  instruction fetch complete this cycle.
REQ-005 SHALL have port dmem_req, dhit  in  1 each  MEM-stage load/store present; data access complete.
REQ-006 SHALL have port idex_MemRead  in  1  EX-stage instruction is a load.
REQ-007 SHALL have port idex_rt  in  5  EX-stage load destination register.
REQ-008 SHALL have port ifid_rs, ifid_rt  in  5 each  ID-stage source registers.
REQ-009 SHALL have port ifid_uses_rt  in  1  ID-stage instruction reads rt.
REQ-010 SHALL have port branch_taken  in  1  MEM-stage branch/jump redirects PC.
REQ-011 SHALL have port halt_in  in  1  MEM-stage instruction is HALT.
REQ-012 SHALL have ports pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN  out  1 each  stage register load enables.
REQ-013 SHALL have ports ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all control zero) instead of input.
REQ-014 SHALL have port halted  out  1  pipeline halted; sticky.
REQ-015 SHALL have port stall_cycles  out  CNT_W  count of cycles with pc_WEN=0.

Function
REQ-016 SHALL implement states RUN, MEM_WAIT, HALTED; enables/flushes are combinational from state and inputs.
REQ-017 SHALL, in RUN with no hazard, assert all five WEN and no flush.
REQ-018 SHALL use per-cycle priority: HALTED > mem wait > branch > load-use > fetch wait.
REQ-019 SHALL treat mem wait as dmem_req=1 and dhit=0: all WEN=0, no flush, state -> MEM_WAIT.
REQ-020 SHALL hold MEM_WAIT with all WEN=0 until dhit=1; that cycle all WEN=1, no flush, next state RUN.
REQ-021 SHALL, on branch_taken in RUN (no mem wait), assert all WEN, ifid_flush, idex_flush, exmem_flush for exactly one cycle, even if ihit=0.
REQ-022 SHALL detect load-use when idex_MemRead=1, idex_rt!=0, and idex_rt==ifid_rs or (ifid_uses_rt=1 and idex_rt==ifid_rt).
REQ-023 SHALL, on load-use, drive pc_WEN=0, ifid_WEN=0, idex_flush=1, other WEN=1, for exactly one cycle per occurrence.
REQ-024 SHALL, on ihit=0 with no higher-priority event, drive pc_WEN=0, ifid_WEN=0, idex_flush=1, other WEN=1.
REQ-025 SHALL, when halt_in=1 and the pipeline is not in mem wait, complete that cycle as in RUN, then enter HALTED.
REQ-026 SHALL, in HALTED, drive all WEN=0, all flush=0, halted=1, ignoring every input except RST.
REQ-027 SHALL not flush register 0 hazards: idex_rt=0 never stalls.
REQ-028 SHALL increment stall_cycles by 1 each cycle pc_WEN=0 outside HALTED, saturating at all-ones.

Reset
REQ-029 SHALL, when RST=1 at a rising edge, enter RUN, clear halted and stall_cycles, from any state including mid-MEM_WAIT.
REQ-030 SHALL drive all WEN=0 and all flush=1 during any cycle RST=1.

Configuration
REQ-031 SHALL compile the stall counter only when HAZARD_PERF_CNT_EN is defined; REQ-028 then applies.
REQ-032 SHALL, without HAZARD_PERF_CNT_EN, tie stall_cycles to 0 and instantiate no counter flops.

Verification
REQ-033 SHALL check load-use: idex_MemRead=1, idex_rt=5, ifid_rs=5 -> one cycle pc_WEN=0, ifid_WEN=0, idex_flush=1, then all WEN=1.
REQ-034 SHALL check mem wait: dmem_req=1, dhit=0 for 3 cycles then dhit=1 -> 3 cycles all WEN=0, 4th cycle all WEN=1, state RUN.
REQ-035 SHALL check branch plus load-use same cycle: branch_taken=1 -> three flushes asserted, pc_WEN=1, no stall.
REQ-036 SHALL check halt: halt_in=1 -> next cycle halted=1, all WEN=0, held for 10 cycles despite ihit/branch toggling; RST=1 -> RUN, halted=0.
REQ-037 SHALL check counter with HAZARD_PERF_CNT_EN, CNT_W=4: 20 stall cycles -> stall_cycles=15; without macro, stall_cycles=0 throughout.
REQ-038 SHALL check register 0: idex_MemRead=1, idex_rt=0, ifid_rs=0 -> no stall.
